serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Sequencing controller for a bit-serial adder datapath.
//   Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
//   Drives one single-bit full-adder cell LSB-first, one bit per clock.
//   Returns the sum and carry-out over a second valid/ready handshake.
//   Sits between an operand producer and a result consumer in the arithmetic path.
// PARAMETERS
//   WIDTH   8                  operand/result width in bits; legal range 1..64
//   CNT_W   $clog2(WIDTH+1)    bit-counter width; derived, do not override
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      controller can accept operands
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  A+B+cin, low WIDTH bits
//   cout       out  1      carry-out of bit WIDTH-1
//   busy       out  1      high in RUN or DONE
//   ovf        out  1      signed overflow; present only with SERIAL_ADD_OVF_EN
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; in_ready=1.
//   Reset values of all other outputs: out_valid, sum, cout, busy, ovf = 0.
//   FSM states and transitions:
//     IDLE -> RUN when in_valid && in_ready.
//     RUN  -> DONE after WIDTH bit-cycles.
//     DONE -> IDLE on out_valid && out_ready.
//   IDLE
//     in_ready=1.
//     On accept: latch a, b into shift regs; carry reg <= cin; cnt <= WIDTH.
//   RUN, each cycle:
//     s = a_sh[0]^b_sh[0]^c.
//     c <= majority(a_sh[0], b_sh[0], c).
//     a_sh, b_sh shift right by 1.
//     Sum shift reg shifts right with s entering at MSB.
//     cnt decrements by 1; on cnt==1 -> DONE.
//   DONE
//     out_valid=1; sum and cout stable and held until out_ready.
//     out_ready may be held high in advance.
//   Latency: accept edge to out_valid high = WIDTH+1 cycles (WIDTH=8 -> 9).
//   Throughput: one op per WIDTH+2 cycles minimum.
//     No accept in the same cycle as result pop.
//   in_ready=0 in RUN and DONE; in_valid is ignored there and inputs are not sampled.
//   WIDTH=1: RUN lasts exactly one cycle.
//   Reset asserted mid-RUN or mid-DONE: operation aborted, result discarded, all regs to reset values.
//   Arithmetic is unsigned modulo 2^WIDTH; the carry is never lost, it appears on cout.
// CONFIGURATION
//   SERIAL_ADD_OVF_EN defined:
//     ovf port exists.
//     In DONE, ovf = carry into MSB XOR cout.
//     Carry into MSB is captured in the final RUN cycle; ovf is held with sum.
//   SERIAL_ADD_OVF_EN undefined: ovf port and its logic absent; all else identical.
// STRUCTURE
//   Shared package serial_add_pkg:
//     FSM state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
//     Default WIDTH constant.
//   Sub-module serial_fa_cell (a, b, ci -> s, co):
//     single-bit full adder built from two half-adder stages and an OR.
//     One instance, combinational.
//   Top holds FSM, counter, operand/sum shift registers, carry flop.
// TESTING (WIDTH=8 unless noted)
//   1. a=0x0F, b=0x01, cin=0
//      -> sum=0x10, cout=0; out_valid rises 9 cycles after accept.
//   2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
//      a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
//   3. Backpressure: out_ready=0 for 5 cycles after DONE.
//      -> sum/cout held, in_ready=0.
//      in_valid pulsed during the stall -> ignored.
//   4. rst_n low at 3rd RUN cycle -> next edge shows IDLE, in_ready=1, out_valid=0.
//      New op 0x22+0x11 after release -> 0x33.
//   5. WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1, latency 2.
//   6. With SERIAL_ADD_OVF_EN: 0x7F+0x01 -> ovf=1; 0xFF+0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/serial_fa_cell.sv
// Single-bit full adder built from two half-adder stages and an OR gate.
// Purely combinational; the controller feeds it one operand bit per clock.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  // First half adder combines the operand bits, second folds in the carry.
  assign ha0_s = a ^ b;
  assign ha0_c = a & b;
  assign s     = ha0_s ^ ci;
  assign ha1_c = ha0_s & ci;
  assign co    = ha0_c | ha1_c;

endmodule : serial_fa_cell

// File: rtl/serial_add_ctrl.sv
// Sequencing controller for a bit-serial adder. Operands are accepted over a
// valid/ready handshake, added LSB-first through one full-adder cell at one
// bit per clock, and the sum/carry-out are offered over a second handshake.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
// output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  // Derived counter width; leave at its default.
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   sum_sh_q;
  logic [WIDTH-1:0]   sum_sh_d;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q;
`endif

  logic fa_s;
  logic fa_co;

  serial_fa_cell u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum bits enter at the MSB so that after WIDTH shifts the LSB-first
  // results line up in their natural positions (also valid for WIDTH=1).
  assign sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  // FSM, bit counter, shift registers and carry flop; all outputs registered.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well, not just the FSM, because
      // sum/cout are visible outputs with defined reset values and an aborted
      // operation must leave no stale result behind.
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            carry_q    <= cin;
            cnt_q      <= CNT_W'(WIDTH);
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q      <= 1'b0;
`endif
          end
        end

        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_co;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            // carry_q is the carry into the MSB during this final bit-cycle.
            ovf_q       <= carry_q ^ fa_co;
`endif
          end
        end

        S_DONE: begin
          // Result held until popped; no accept in the same cycle as a pop.
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_sh_q;
  assign cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: a table of operand vectors with
// hand-computed results, plus sequences for backpressure, pre-asserted
// out_ready, reset abort, and a WIDTH=1 instance.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
  logic       w1_ovf;
`endif

  logic       w1_in_valid;
  logic       w1_in_ready;
  logic [0:0] w1_a;
  logic [0:0] w1_b;
  logic       w1_cin;
  logic       w1_out_valid;
  logic       w1_out_ready;
  logic [0:0] w1_sum;
  logic       w1_cout;
  logic       w1_busy;

  int n_checks = 0;
  int n_errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .a         (w1_a),
    .b         (w1_b),
    .cin       (w1_cin),
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .sum       (w1_sum),
    .cout      (w1_cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (w1_ovf),
`endif
    .busy      (w1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one operand set at a negedge and waits for out_valid.
  // lat counts clock edges from the accept edge (inclusive) to the edge
  // after which out_valid is seen high; expected WIDTH+1.
  task automatic start_and_wait(input logic [7:0] ai, input logic [7:0] bi,
                                input logic ci, output int lat);
    @(negedge clk);
    a        = ai;
    b        = bi;
    cin      = ci;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    cin      = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;

    //              a      b      cin   sum    cout  ovf
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    a            = 8'h00;
    b            = 8'h00;
    cin          = 1'b0;
    out_ready    = 1'b0;
    w1_in_valid  = 1'b0;
    w1_a         = 1'b0;
    w1_b         = 1'b0;
    w1_cin       = 1'b0;
    w1_out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset in_ready",  64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy",      64'(busy), 64'd0);
    check("reset sum",       64'(sum), 64'd0);
    check("reset cout",      64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("reset ovf",       64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("idle in_ready", 64'(in_ready), 64'd1);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd9);
      check($sformatf("vec%0d sum", i), 64'(sum), 64'(vecs[i].exp_sum));
      check($sformatf("vec%0d cout", i), 64'(cout), 64'(vecs[i].exp_cout));
`ifdef SERIAL_ADD_OVF_EN
      check($sformatf("vec%0d ovf", i), 64'(ovf), 64'(vecs[i].exp_ovf));
`endif
      check($sformatf("vec%0d in_ready in DONE", i), 64'(in_ready), 64'd0);
      pop();
      check($sformatf("vec%0d out_valid after pop", i), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d in_ready after pop", i), 64'(in_ready), 64'd1);
    end

    // Busy/in_ready during RUN.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("run busy",     64'(busy), 64'd1);
    check("run in_ready", 64'(in_ready), 64'd0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", 64'(lat), 64'd9);

    // Backpressure: hold for 5 cycles with a stray in_valid pulse.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = 8'hEE; b = 8'hEE; cin = 1'b1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      check($sformatf("bp%0d sum", i), 64'(sum), 64'h46);
      check($sformatf("bp%0d cout", i), 64'(cout), 64'd0);
      check($sformatf("bp%0d out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp held sum", 64'(sum), 64'h46);
    pop();
    check("bp pop out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("bp stray ignored busy", 64'(busy), 64'd0);
    check("bp stray ignored in_ready", 64'(in_ready), 64'd1);

    // out_ready held high in advance: result lives exactly one cycle.
    out_ready = 1'b1;
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("early ready latency", 64'(lat), 64'd9);
    check("early ready sum", 64'(sum), 64'h03);
    @(negedge clk);
    check("early ready out_valid drop", 64'(out_valid), 64'd0);
    check("early ready in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    // Reset in the third RUN cycle aborts the operation.
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-abort busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort sum", 64'(sum), 64'd0);
    @(posedge clk);
    #1;
    check("abort edge in_ready", 64'(in_ready), 64'd1);
    check("abort edge out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_and_wait(8'h22, 8'h11, 1'b0, lat);
    check("post-reset latency", 64'(lat), 64'd9);
    check("post-reset sum", 64'(sum), 64'h33);
    check("post-reset cout", 64'(cout), 64'd0);
    pop();

    // WIDTH=1 instance: 1+1+1 = 3 -> sum 1, cout 1, latency 2.
    @(negedge clk);
    w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1; w1_in_valid = 1'b1;
    @(negedge clk);
    w1_in_valid = 1'b0;
    check("w1 run busy", 64'(w1_busy), 64'd1);
    lat = 1;
    while (!w1_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("w1 latency", 64'(lat), 64'd2);
    check("w1 sum", 64'(w1_sum), 64'd1);
    check("w1 cout", 64'(w1_cout), 64'd1);
    w1_out_ready = 1'b1;
    @(negedge clk);
    w1_out_ready = 1'b0;
    check("w1 pop out_valid", 64'(w1_out_valid), 64'd0);

    // WIDTH=1: 0+1+0 -> sum 1, cout 0.
    @(negedge clk);
    w1_a = 1'b0; w1_b = 1'b1; w1_cin = 1'b0; w1_in_valid = 1'b1;
    @(negedge clk);
    w1_in_valid = 1'b0;
    lat = 1;
    while (!w1_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("w1b latency", 64'(lat), 64'd2);
    check("w1b sum", 64'(w1_sum), 64'd1);
    check("w1b cout", 64'(w1_cout), 64'd0);
    w1_out_ready = 1'b1;
    @(negedge clk);
    w1_out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_add_ctrl
